// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage enables and flush controls out.
// The controller itself adds no latency; all controls are combinational.
// No handshake; the pipeline must honour the enables in the cycle they are shown.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID / EX hazard sources
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             ex_redirect;
  // MEM stage / data memory
  logic             mem_memread;
  logic             mem_memwrite;
  logic             dmem_ready;
  logic             dmem_req;
  // stage controls
  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             pc_redirect;
  // status
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  // pipeline side: reports stage contents, obeys controls
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_redirect, mem_memread, mem_memwrite, dmem_ready,
    input  dmem_req, pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush,
           id_ex_flush, mem_wb_bubble, pc_redirect, mem_timeout, stall_cnt
  );

  // controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_redirect, mem_memread, mem_memwrite, dmem_ready,
    output dmem_req, pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush,
           id_ex_flush, mem_wb_bubble, pc_redirect, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, EX redirect, dmem wait, timeout halt).
// Zero latency: controls are combinational from state and current stage status.
// A dmem wait freezes PC..EX/MEM and bubbles MEM/WB; TIMEOUT consecutive waits halt until rst.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // wait_cnt value seen during the last tolerated wait cycle
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       wait_cnt;
  logic [7:0]       wait_cnt_nxt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             halted;
  logic             dmem_req;
  logic             mem_stall;
  logic             load_use;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             count_stall;

  // Hazard detection: memory wait and load-use dependency on the EX load.
  always_comb begin
    halted      = (state == HALT);
    dmem_req    = (bus.mem_memread | bus.mem_memwrite) & ~halted;
    mem_stall   = dmem_req & ~bus.dmem_ready;
    rs1_hit     = bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd);
    rs2_hit     = bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd);
    load_use    = bus.ex_memread & (bus.ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    // a redirect squashes the dependent ID instruction, so it is not a stall
    count_stall = ~halted & (mem_stall | (load_use & ~bus.ex_redirect));
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = mem_stall ? (wait_cnt + 8'd1) : 8'd0;
    case (state)
      RUN: begin
        if (mem_stall) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_stall && (wait_cnt == WAIT_LAST)) state_nxt = HALT;
        else if (bus.dmem_ready)                  state_nxt = RUN;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Stage controls, highest-priority condition first; reset forces the safe set.
  always_comb begin
    bus.dmem_req      = dmem_req;
    bus.pc_we         = 1'b1;
    bus.if_id_we      = 1'b1;
    bus.id_ex_we      = 1'b1;
    bus.ex_mem_we     = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.mem_wb_bubble = 1'b0;
    bus.pc_redirect   = 1'b0;
    if (rst || halted) begin
      bus.dmem_req      = 1'b0;
      bus.pc_we         = 1'b0;
      bus.if_id_we      = 1'b0;
      bus.id_ex_we      = 1'b0;
      bus.ex_mem_we     = 1'b0;
      bus.if_id_flush   = 1'b1;
      bus.id_ex_flush   = 1'b1;
      bus.mem_wb_bubble = 1'b1;
    end else if (mem_stall) begin
      // EX is frozen, so a pending redirect is re-evaluated after release
      bus.pc_we         = 1'b0;
      bus.if_id_we      = 1'b0;
      bus.id_ex_we      = 1'b0;
      bus.ex_mem_we     = 1'b0;
      bus.mem_wb_bubble = 1'b1;
    end else if (bus.ex_redirect) begin
      bus.pc_redirect   = 1'b1;
      bus.if_id_flush   = 1'b1;
      bus.id_ex_flush   = 1'b1;
    end else if (load_use) begin
      bus.pc_we         = 1'b0;
      bus.if_id_we      = 1'b0;
      bus.id_ex_flush   = 1'b1;
    end
  end

  // State, wait counter, sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == HALT) timeout_q <= 1'b1;
    end
  end

  // Saturating stall performance counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (count_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.mem_timeout = timeout_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
